// File: rtl/text_overlay_pipe_pkg.sv
// text_overlay_pipe_pkg: shared geometry, ASCII constants, mode/FSM encodings and BCD helper
package text_overlay_pipe_pkg;
  localparam int CHAR_H_SH = 3;
  localparam int ROW_W = 4;
  localparam logic [6:0] ASCII_SPACE = 7'd32;
  localparam logic [6:0] ASCII_A_BASE = 7'd64;
  localparam logic [6:0] ASCII_0 = 7'd48;
  typedef enum logic [1:0] {MODE_TEXT, MODE_DICT, MODE_NUM, MODE_TEXT3} mode_e;
  typedef enum logic [1:0] {BCD_IDLE, BCD_SHIFT, BCD_DONE} bcd_state_e;
  function automatic logic [3:0] dabble(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/ascii_rom.sv
// ascii_rom: portrait glyph ROM, address {ascii,row}, one-cycle synchronous read
module ascii_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  logic [39:0] g;
  logic [39:0] gs;
  logic [7:0] data_d, data_q;
  always_comb begin
    case (addr[10:4])
      7'd32: g = 40'h00_00_00_00_00;
      7'd48: g = 40'h3E_51_49_45_3E;
      7'd49: g = 40'h00_42_7F_40_00;
      7'd50: g = 40'h42_61_51_49_46;
      7'd51: g = 40'h21_41_45_4B_31;
      7'd52: g = 40'h18_14_12_7F_10;
      7'd53: g = 40'h27_45_45_45_39;
      7'd54: g = 40'h3C_4A_49_49_30;
      7'd55: g = 40'h01_71_09_05_03;
      7'd56: g = 40'h36_49_49_49_36;
      7'd57: g = 40'h06_49_49_29_1E;
      7'd65: g = 40'h7E_11_11_11_7E;
      7'd66: g = 40'h7F_49_49_49_36;
      7'd67: g = 40'h3E_41_41_41_22;
      7'd68: g = 40'h7F_41_41_22_1C;
      7'd69: g = 40'h7F_49_49_49_41;
      default: g = 40'hFF_81_81_81_FF;
    endcase
    gs = g << (8 * int'(addr[3:0]));
    data_d = gs[39:32];
  end
  always_ff @(posedge clk) data_q <= data_d;
  assign data = data_q;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, NUM_W shift cycles then one DONE cycle
module bin2bcd_seq
  import text_overlay_pipe_pkg::*;
#(
  parameter int NUM_W = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [NUM_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   blank_mask
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_W + 1);
  bcd_state_e state_q;
  logic [BW-1:0] bcd_q, adj;
  logic [NUM_W-1:0] bin_q;
  logic [CW-1:0] cnt_q;
  logic lead;
  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) adj[4*i+:4] = dabble(bcd_q[4*i+:4]);
    lead = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lead = lead && bcd_q[4*k+:4] == 4'd0;
      blank_mask[k] = lead && k != 0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= BCD_IDLE;
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      state_q <= BCD_SHIFT;
      bcd_q <= '0;
      bin_q <= bin;
      cnt_q <= '0;
    end else begin
      case (state_q)
        BCD_SHIFT: begin
          {bcd_q, bin_q} <= {adj, bin_q} << 1;
          cnt_q <= cnt_q + 1'b1;
          state_q <= cnt_q == CW'(NUM_W - 1) ? BCD_DONE : BCD_SHIFT;
        end
        BCD_DONE: state_q <= BCD_IDLE;
        default: state_q <= BCD_IDLE;
      endcase
    end
  assign busy = state_q != BCD_IDLE;
  assign done = state_q == BCD_DONE && !load;
  assign bcd = bcd_q;
endmodule

// File: rtl/text_overlay_pipe.sv
// text_overlay_pipe: two-stage text/dict/number overlay with blinking cursor over a pixel window
module text_overlay_pipe
  import text_overlay_pipe_pkg::*;
#(
  parameter int NCHARS = 25,
  parameter int NUM_W = 10,
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_FR = 30,
  parameter int COL_OK = 3,
  parameter int COL_BAD = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [9:0]            vgax,
  input  logic [9:0]            vgay,
  input  logic [9:0]            sx,
  input  logic [9:0]            sy,
  input  logic [9:0]            ex,
  input  logic [9:0]            ey,
  input  logic [1:0]            mode,
  input  logic [NCHARS*5-1:0]   text,
  input  logic [5:0]            correct,
  input  logic [5:0]            tot,
  input  logic                  cursor_en,
  input  logic                  frame_tick,
  input  logic [NUM_W-1:0]      num,
  input  logic                  num_load,
  input  logic [2:0]            font_color,
  input  logic [2:0]            background_color,
  output logic [2:0]            pixel,
  output logic                  num_busy
);
  localparam int BCW = $clog2(BLINK_FR > 1 ? BLINK_FR : 2);
  logic [9:0] dy;
  logic [9-CHAR_H_SH:0] id;
  logic [ROW_W-1:0] row;
  logic [4:0] code;
  logic [3:0] digit;
  logic nblank;
  logic [6:0] ascii;
  logic [7:0] rom_data;
  logic show_d, show_q, cur_d, cur_q, glyph, blink_d, blink_q, num_done;
  logic [2:0] bit_d, bit_q, bg_d, bg_q, fg_q, pixel_d, pixel_q;
  logic [BCW-1:0] blink_cnt_d, blink_cnt_q;
  logic [4*NUM_DIGITS-1:0] num_bcd, digits_d, digits_q;
  logic [NUM_DIGITS-1:0] num_blank, blank_d, blank_q;
  bin2bcd_seq #(.NUM_W(NUM_W), .NUM_DIGITS(NUM_DIGITS)) conv (
    .clk(clk), .rst_n(rst_n), .load(num_load), .bin(num), .busy(num_busy),
    .done(num_done), .bcd(num_bcd), .blank_mask(num_blank)
  );
  ascii_rom rom (.clk(clk), .addr({ascii, row}), .data(rom_data));
  always_comb begin
    dy = vgay - sy;
    id = dy[9:CHAR_H_SH];
    row = vgax[ROW_W-1:0] - sx[ROW_W-1:0];
    bit_d = dy[CHAR_H_SH-1:0];
    code = 5'd0;
    for (int i = 0; i < NCHARS; i++) code = int'(id) == i ? text[5*i+:5] : code;
    digit = 4'd0;
    nblank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = int'(id) == i ? digits_q[4*(NUM_DIGITS-1-i)+:4] : digit;
      nblank = int'(id) == i ? !blank_q[NUM_DIGITS-1-i] : nblank;
    end
    ascii = mode == MODE_NUM ? (nblank ? ASCII_0 + 7'(digit) : ASCII_SPACE)
          : (code != 5'd0 ? ASCII_A_BASE + 7'(code) : ASCII_SPACE);
    show_d = valid && vgax >= sx && vgay >= sy && vgax < ex && vgay < ey;
    cur_d = mode != MODE_NUM && cursor_en && blink_q && id == {1'b0, tot} && int'(tot) < NCHARS;
    bg_d = mode != MODE_DICT ? background_color
         : id < {1'b0, correct} ? 3'(COL_OK)
         : id < {1'b0, tot} ? 3'(COL_BAD) : background_color;
    glyph = rom_data[~bit_q];
    pixel_d = !show_q ? 3'd0 : cur_q ? (glyph ? bg_q : fg_q) : (glyph ? fg_q : bg_q);
    blink_cnt_d = !frame_tick ? blink_cnt_q : blink_cnt_q == BCW'(BLINK_FR - 1) ? '0 : blink_cnt_q + 1'b1;
    blink_d = blink_q ^ (frame_tick && blink_cnt_q == BCW'(BLINK_FR - 1));
    digits_d = num_done ? num_bcd : digits_q;
    blank_d = num_done ? num_blank : blank_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      show_q <= 1'b0;
      cur_q <= 1'b0;
      bit_q <= '0;
      fg_q <= '0;
      bg_q <= '0;
      pixel_q <= '0;
      blink_cnt_q <= '0;
      blink_q <= 1'b0;
      digits_q <= '0;
      blank_q <= '1;
    end else begin
      show_q <= show_d;
      cur_q <= cur_d;
      bit_q <= bit_d;
      fg_q <= font_color;
      bg_q <= bg_d;
      pixel_q <= pixel_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q <= blink_d;
      digits_q <= digits_d;
      blank_q <= blank_d;
    end
  assign pixel = pixel_q;
endmodule

// File: tb/tb_text_overlay_pipe.sv
// tb_text_overlay_pipe: directed stimulus, spec-level pixel/busy model checked every cycle plus literal pins
module tb_text_overlay_pipe;
  localparam int NCHARS = 25, NUM_W = 10, ND = 4, BF = 2;
  logic clk = 0, rst_n = 0, valid = 0;
  logic [9:0] vgax = 0, vgay = 0, sx = 0, sy = 0, ex = 10'd16, ey = 10'd200;
  logic [1:0] mode = 0;
  logic [NCHARS*5-1:0] text = '0;
  logic [5:0] correct = 0, tot = 0;
  logic cursor_en = 0, frame_tick = 0, num_load = 0;
  logic [NUM_W-1:0] num = 0;
  logic [2:0] font_color = 3'd7, background_color = 3'd1;
  logic [2:0] pixel;
  logic num_busy;
  int vecs = 0, errs = 0;
  int ticks = 0, disp_val = 0, pend = 0, busy_left = 0;
  bit disp_valid = 0;
  logic [2:0] exp_cur = 0, exp_prev = 0;

  always #5 clk = ~clk;

  text_overlay_pipe #(.NCHARS(NCHARS), .NUM_W(NUM_W), .NUM_DIGITS(ND), .BLINK_FR(BF)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .vgax(vgax), .vgay(vgay), .sx(sx), .sy(sy),
    .ex(ex), .ey(ey), .mode(mode), .text(text), .correct(correct), .tot(tot),
    .cursor_en(cursor_en), .frame_tick(frame_tick), .num(num), .num_load(num_load),
    .font_color(font_color), .background_color(background_color), .pixel(pixel), .num_busy(num_busy)
  );

  function automatic bit glyph(int ch, int row, int b);
    logic [39:0] g;
    logic [7:0] by;
    case (ch)
      32: g = 40'h00_00_00_00_00;
      48: g = 40'h3E_51_49_45_3E;
      49: g = 40'h00_42_7F_40_00;
      50: g = 40'h42_61_51_49_46;
      51: g = 40'h21_41_45_4B_31;
      52: g = 40'h18_14_12_7F_10;
      53: g = 40'h27_45_45_45_39;
      54: g = 40'h3C_4A_49_49_30;
      55: g = 40'h01_71_09_05_03;
      56: g = 40'h36_49_49_49_36;
      57: g = 40'h06_49_49_29_1E;
      65: g = 40'h7E_11_11_11_7E;
      66: g = 40'h7F_49_49_49_36;
      67: g = 40'h3E_41_41_41_22;
      68: g = 40'h7F_41_41_22_1C;
      69: g = 40'h7F_49_49_49_41;
      default: g = 40'hFF_81_81_81_FF;
    endcase
    if (row > 4) return 1'b0;
    by = g[39-8*row -: 8];
    return by[7-b];
  endfunction

  function automatic logic [2:0] model_pixel();
    int x, y, lx, ly, ux, uy, dx, dy, id, row, b, ch, code, p, pw, m;
    logic [2:0] bgc;
    bit g, cur, blank;
    x = int'(vgax); y = int'(vgay); lx = int'(sx); ly = int'(sy); ux = int'(ex); uy = int'(ey);
    m = int'(mode);
    if (!(valid && x >= lx && y >= ly && x < ux && y < uy)) return 3'd0;
    dx = x - lx; dy = y - ly; id = dy / 8; row = dx % 16; b = dy % 8;
    ch = 32;
    if (m == 2) begin
      if (id < ND) begin
        p = ND - 1 - id;
        pw = 10 ** p;
        blank = !disp_valid || (p > 0 && disp_val < pw);
        if (!blank) ch = 48 + (disp_val / pw) % 10;
      end
    end else begin
      code = id < NCHARS ? int'(text[5*id+:5]) : 0;
      if (code != 0) ch = 64 + code;
    end
    g = glyph(ch, row, b);
    bgc = m != 1 ? background_color : id < int'(correct) ? 3'd3 : id < int'(tot) ? 3'd2 : background_color;
    cur = m != 2 && cursor_en && (ticks / BF) % 2 == 1 && id == int'(tot) && int'(tot) < NCHARS;
    return cur ? (g ? bgc : font_color) : (g ? font_color : bgc);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      ticks <= 0; disp_valid <= 0; disp_val <= 0; busy_left <= 0; exp_prev <= 0; exp_cur <= 0;
    end else begin
      exp_prev <= exp_cur;
      exp_cur <= model_pixel();
      if (frame_tick) ticks <= ticks + 1;
      if (num_load) begin
        busy_left <= NUM_W + 1;
        pend <= int'(num) % (10 ** ND);
      end else if (busy_left > 0) begin
        busy_left <= busy_left - 1;
        if (busy_left == 1) begin
          disp_valid <= 1;
          disp_val <= pend;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t (x=%0d y=%0d mode=%0d)", nm, act, want, $time, vgax, vgay, mode);
    end
  endtask

  always @(negedge clk) begin
    chk("pixel_model", 32'(pixel), rst_n ? 32'(exp_prev) : 32'd0);
    chk("busy_model", 32'(num_busy), rst_n ? 32'(busy_left > 0) : 32'd0);
  end

  task automatic px(input int x, input int y);
    @(negedge clk);
    vgax = 10'(x);
    vgay = 10'(y);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) px(x, y);
  endtask

  task automatic lit(input string nm, input int x, input int y, input logic [2:0] want);
    px(x, y);
    @(negedge clk);
    @(negedge clk);
    chk(nm, 32'(pixel), 32'(want));
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
  endtask

  task automatic load(input int n);
    @(negedge clk);
    num = NUM_W'(n);
    num_load = 1;
    @(negedge clk);
    num_load = 0;
  endtask

  task automatic busy_run(input string nm);
    int c = 0;
    for (int i = 0; i < 40; i++) begin
      if (num_busy) c++;
      px(i % 16, i % 32);
    end
    chk(nm, 32'(c), 32'(NUM_W + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_pixel", 32'(pixel), 32'd0);
    chk("reset_busy", 32'(num_busy), 32'd0);
    rst_n = 1;
    valid = 1;
    text[4:0] = 5'd1;
    text[9:5] = 5'd2;
    scan(0, 15, 0, 15);
    lit("A_row0_bit1", 0, 1, 3'd7);
    lit("A_row0_bit0", 0, 0, 3'd1);
    lit("A_row1_bit3", 1, 3, 3'd7);
    lit("A_row1_bit2", 1, 2, 3'd1);
    lit("A_row5_blank", 5, 1, 3'd1);
    sx = 10'd4; sy = 10'd8; ex = 10'd20; ey = 10'd24;
    scan(0, 23, 4, 27);
    lit("win_inside", 4, 9, 3'd7);
    lit("win_left", 3, 9, 3'd0);
    lit("win_right_excl", 20, 9, 3'd0);
    valid = 0;
    lit("not_valid", 4, 9, 3'd0);
    valid = 1;
    mode = 2'd3;
    scan(0, 23, 4, 27);
    sx = 0; sy = 0; ex = 10'd16; ey = 10'd200;
    mode = 2'd1;
    text[14:10] = 5'd3; text[19:15] = 5'd4; text[24:20] = 5'd5; text[29:25] = 5'd1;
    correct = 6'd2; tot = 6'd4;
    scan(0, 15, 0, 47);
    lit("dict_id0_ok", 8, 0, 3'd3);
    lit("dict_id1_ok", 8, 8, 3'd3);
    lit("dict_id2_bad", 8, 16, 3'd2);
    lit("dict_id3_bad", 8, 24, 3'd2);
    lit("dict_id4_bg", 8, 32, 3'd1);
    lit("dict_glyph_fg", 0, 1, 3'd7);
    mode = 2'd0; cursor_en = 1; tot = 6'd3;
    lit("cursor_off", 8, 24, 3'd1);
    tick(); tick();
    lit("cursor_on_bg", 8, 24, 3'd7);
    lit("cursor_on_glyph", 0, 25, 3'd1);
    lit("cursor_other_id", 8, 16, 3'd1);
    scan(0, 15, 16, 31);
    tick(); tick();
    lit("cursor_off_again", 8, 24, 3'd1);
    mode = 2'd1;
    tick(); tick();
    scan(0, 15, 16, 31);
    cursor_en = 0;
    mode = 2'd2;
    scan(0, 15, 0, 31);
    load(907);
    busy_run("busy_907");
    chk("busy_907_done", 32'(num_busy), 32'd0);
    lit("num907_id0_blank", 0, 5, 3'd1);
    lit("num907_9", 0, 13, 3'd7);
    lit("num907_0", 0, 22, 3'd7);
    lit("num907_7", 0, 31, 3'd7);
    lit("num907_7_off", 0, 24, 3'd1);
    scan(0, 15, 0, 31);
    load(123);
    px(0, 13); px(0, 13);
    load(45);
    busy_run("busy_restart");
    lit("num45_old9_gone", 0, 13, 3'd1);
    lit("num45_4", 0, 19, 3'd7);
    lit("num45_5", 0, 31, 3'd7);
    scan(0, 15, 0, 31);
    load(0);
    busy_run("busy_zero");
    lit("num0_last_0", 0, 26, 3'd7);
    lit("num0_id2_blank", 0, 18, 3'd1);
    load(999);
    px(0, 26); px(0, 26); px(0, 26);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_pixel", 32'(pixel), 32'd0);
    chk("async_rst_busy", 32'(num_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    valid = 0;
    lit("post_rst_invalid", 0, 26, 3'd0);
    valid = 1;
    lit("post_rst_blank", 0, 26, 3'd1);
    chk("post_rst_busy", 32'(num_busy), 32'd0);
    scan(0, 15, 0, 31);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
